// File: rtl/hbridge_pkg.sv
// Shared encodings for the H-bridge deadtime controller: signed command
// levels, switch patterns per level, channel FSM states and the pattern lookup.
package hbridge_pkg;

    // Signed 2-bit command levels. The one unused code (2'b10) is illegal on
    // the cmd input. Internally it also encodes "bridge off" in cur, because
    // its pattern is all switches open.
    localparam logic [1:0] LVL_ZERO    = 2'b00;
    localparam logic [1:0] LVL_POS     = 2'b01;
    localparam logic [1:0] LVL_NEG     = 2'b11;
    localparam logic [1:0] LVL_ILLEGAL = 2'b10;
    localparam logic [1:0] LVL_OFF     = 2'b10;

    // Gate patterns for a non-inverted bridge.
    localparam logic [3:0] PAT_POS  = 4'b0110;
    localparam logic [3:0] PAT_ZERO = 4'b0101;
    localparam logic [3:0] PAT_NEG  = 4'b1001;
    localparam logic [3:0] PAT_OFF  = 4'b0000;

    // Channel FSM state type and its encodings.
    typedef logic [1:0] chan_state_t;
    localparam chan_state_t ST_OFF    = 2'd0;
    localparam chan_state_t ST_STEADY = 2'd1;
    localparam chan_state_t ST_DEAD   = 2'd2;

    // Switch pattern for a level. inv swaps the +1 and -1 patterns.
    // The off/illegal code opens every switch.
    function automatic logic [3:0] lvl_pat(input logic [1:0] lvl, input logic inv);
        logic [3:0] p;
        case (lvl)
            LVL_POS:  p = inv ? PAT_NEG : PAT_POS;
            LVL_NEG:  p = inv ? PAT_POS : PAT_NEG;
            LVL_ZERO: p = PAT_ZERO;
            default:  p = PAT_OFF;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/hbridge_dt_chan.sv
// One H-bridge channel. It runs an OFF/STEADY/DEAD FSM that inserts a
// deadtime before each level change. During a transition only the switches
// shared by the old and the new pattern stay closed.
module hbridge_dt_chan
    import hbridge_pkg::*;
#(
    parameter int DT_W = 8,
    parameter bit INV  = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            force_off,
    input  logic [DT_W-1:0] deadtime,
    input  logic [1:0]      cmd,
    output logic [3:0]      gate,
    output logic            busy,
    output logic            cmd_err
);

    chan_state_t     state_reg, state_next;
    logic [1:0]      cur_reg, cur_next;
    logic [1:0]      tgt_reg, tgt_next;
    logic [DT_W-1:0] cnt_reg, cnt_next;
    logic [DT_W-1:0] dt_lat_reg, dt_lat_next;
    logic            cmd_legal;

    assign cmd_legal = (cmd != LVL_ILLEGAL);
    assign cmd_err   = ~cmd_legal;

    // Next-state logic. A forced shutdown overrides every other transition.
    always_comb begin
        state_next  = state_reg;
        cur_next    = cur_reg;
        tgt_next    = tgt_reg;
        cnt_next    = cnt_reg;
        dt_lat_next = dt_lat_reg;
        if (force_off) begin
            state_next = ST_OFF;
            cnt_next   = '0;
        end else begin
            case (state_reg)
                ST_OFF: begin
                    // Leave OFF through a deadtime. cur=OFF keeps all switches
                    // open until the first level is reached.
                    state_next  = ST_DEAD;
                    cur_next    = LVL_OFF;
                    tgt_next    = cmd_legal ? cmd : LVL_ZERO;
                    cnt_next    = '0;
                    dt_lat_next = deadtime;
                end
                ST_STEADY: begin
                    if (cmd_legal && (cmd != cur_reg)) begin
                        state_next  = ST_DEAD;
                        tgt_next    = cmd;
                        cnt_next    = '0;
                        dt_lat_next = deadtime;
                    end
                end
                ST_DEAD: begin
                    if (cmd_legal && (cmd == cur_reg)) begin
                        // Back to the old level. No complementary switch has been
                        // closed, so no deadtime is needed.
                        state_next = ST_STEADY;
                    end else if (cmd_legal && (cmd != tgt_reg)) begin
                        // New target mid-transition: restart the deadtime.
                        tgt_next    = cmd;
                        cnt_next    = '0;
                        dt_lat_next = deadtime;
                    end else if (cnt_reg == dt_lat_reg) begin
                        state_next = ST_STEADY;
                        cur_next   = tgt_reg;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
                default: state_next = ST_OFF;
            endcase
        end
    end

    // State registers. Reset forces OFF immediately, which opens all gates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_OFF;
            cur_reg    <= LVL_ZERO;
            tgt_reg    <= LVL_ZERO;
            cnt_reg    <= '0;
            dt_lat_reg <= '0;
        end else begin
            state_reg  <= state_next;
            cur_reg    <= cur_next;
            tgt_reg    <= tgt_next;
            cnt_reg    <= cnt_next;
            dt_lat_reg <= dt_lat_next;
        end
    end

    // Moore gate decode, driven only from registered state.
    always_comb begin
        gate = PAT_OFF;
        case (state_reg)
            ST_STEADY: gate = lvl_pat(cur_reg, INV);
            ST_DEAD:   gate = lvl_pat(cur_reg, INV) & lvl_pat(tgt_reg, INV);
            default:   gate = PAT_OFF;
        endcase
    end

    assign busy = (state_reg == ST_DEAD);

endmodule

// File: rtl/hbridge_deadtime.sv
// Multi-bridge deadtime controller. It holds the latched fault and the shared
// shutdown condition, and instantiates one channel per bridge.
module hbridge_deadtime
    import hbridge_pkg::*;
#(
    parameter int                  N_BRIDGE = 2,
    parameter int                  DT_W     = 8,
    parameter logic [N_BRIDGE-1:0] INV_MASK = 2'b10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  fault_in,
    input  logic                  fault_clr,
    input  logic [DT_W-1:0]       deadtime,
    input  logic [2*N_BRIDGE-1:0] cmd,
    output logic [4*N_BRIDGE-1:0] gate,
    output logic [N_BRIDGE-1:0]   busy,
    output logic [N_BRIDGE-1:0]   cmd_err,
    output logic                  fault
);

    logic fault_reg;
    logic force_off;

    // Latched trip. A trip request wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_reg <= 1'b0;
        end else if (fault_in) begin
            fault_reg <= 1'b1;
        end else if (fault_clr) begin
            fault_reg <= 1'b0;
        end
    end

    assign fault     = fault_reg;
    assign force_off = ~en | fault_in | fault_reg;

    generate
        for (genvar gi = 0; gi < N_BRIDGE; gi++) begin : g_chan
            hbridge_dt_chan #(
                .DT_W (DT_W),
                .INV  (INV_MASK[gi])
            ) u_chan (
                .clk       (clk),
                .rst_n     (rst_n),
                .force_off (force_off),
                .deadtime  (deadtime),
                .cmd       (cmd[2*gi +: 2]),
                .gate      (gate[4*gi +: 4]),
                .busy      (busy[gi]),
                .cmd_err   (cmd_err[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_hbridge_deadtime.sv
// Table-driven bench for hbridge_deadtime with two bridges; bridge 1 is inverted.
// Each table row gives the inputs for one clock edge and the outputs expected
// after that edge.
module tb_hbridge_deadtime;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       fault_in;
    logic       fault_clr;
    logic [7:0] deadtime;
    logic [3:0] cmd;
    logic [7:0] gate;
    logic [1:0] busy;
    logic [1:0] cmd_err;
    logic       fault;

    int errors = 0;
    int checks = 0;

    hbridge_deadtime #(
        .N_BRIDGE (2),
        .DT_W     (8),
        .INV_MASK (2'b10)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .fault_in  (fault_in),
        .fault_clr (fault_clr),
        .deadtime  (deadtime),
        .cmd       (cmd),
        .gate      (gate),
        .busy      (busy),
        .cmd_err   (cmd_err),
        .fault     (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       fi;
        logic       fc;
        logic [7:0] dt;
        logic [3:0] cmd;
        logic [7:0] gate;
        logic [1:0] busy;
        logic [1:0] err;
        logic       fault;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic e, input logic fi, input logic fc, input logic [7:0] dt,
                       input logic [3:0] c, input logic [7:0] g, input logic [1:0] b,
                       input logic [1:0] er, input logic f);
        vec_t v;
        v.en = e; v.fi = fi; v.fc = fc; v.dt = dt; v.cmd = c;
        v.gate = g; v.busy = b; v.err = er; v.fault = f;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [7:0] g, input logic [1:0] b,
                         input logic [1:0] er, input logic f);
        checks++;
        if (gate !== g || busy !== b || cmd_err !== er || fault !== f) begin
            errors++;
            $display("FAIL %s: got gate=%b busy=%b err=%b fault=%b, want gate=%b busy=%b err=%b fault=%b",
                     name, gate, busy, cmd_err, fault, g, b, er, f);
        end else begin
            $display("ok   %s: gate=%b busy=%b err=%b fault=%b", name, gate, busy, cmd_err, fault);
        end
    endtask

    initial begin
        // cmd layout is {bridge1, bridge0}: +1=01, 0=00, -1=11, illegal=10.
        // Bridge 1 is inverted, so its +1 pattern is 1001.
        // Power-up: deadtime 3 from OFF gives 4 DEAD cycles at 0000, then level 0.
        for (int i = 0; i < 4; i++) add(1, 0, 0, 8'd3, 4'b0000, 8'h00, 2'b11, 2'b00, 0);
        add(1, 0, 0, 8'd3, 4'b0000, 8'h55, 2'b00, 2'b00, 0);
        // Both bridges go to +1 with deadtime 0, giving exactly one DEAD cycle.
        add(1, 0, 0, 8'd0, 4'b0101, 8'h14, 2'b11, 2'b00, 0);
        add(1, 0, 0, 8'd0, 4'b0101, 8'h96, 2'b00, 2'b00, 0);
        add(1, 0, 0, 8'd0, 4'b0101, 8'h96, 2'b00, 2'b00, 0);
        // Bridge0 goes +1 -> -1 with deadtime 2; bridge1 holds +1 (shows 1001).
        for (int i = 0; i < 3; i++) add(1, 0, 0, 8'd2, 4'b0111, 8'h90, 2'b01, 2'b00, 0);
        add(1, 0, 0, 8'd2, 4'b0111, 8'h99, 2'b00, 2'b00, 0);
        // Bridge0 returns to +1.
        add(1, 0, 0, 8'd0, 4'b0101, 8'h90, 2'b01, 2'b00, 0);
        add(1, 0, 0, 8'd0, 4'b0101, 8'h96, 2'b00, 2'b00, 0);
        // Bridge0 goes +1 -> 0 (gate 0100). It is retargeted to -1 at cnt=1.
        add(1, 0, 0, 8'd3, 4'b0100, 8'h94, 2'b01, 2'b00, 0);
        add(1, 0, 0, 8'd3, 4'b0100, 8'h94, 2'b01, 2'b00, 0);
        for (int i = 0; i < 4; i++) add(1, 0, 0, 8'd3, 4'b0111, 8'h90, 2'b01, 2'b00, 0);
        add(1, 0, 0, 8'd3, 4'b0111, 8'h99, 2'b00, 2'b00, 0);
        // In DEAD, a command equal to cur returns to STEADY on the next edge.
        add(1, 0, 0, 8'd3, 4'b0100, 8'h91, 2'b01, 2'b00, 0);
        add(1, 0, 0, 8'd3, 4'b0111, 8'h99, 2'b00, 2'b00, 0);
        // Bridge0 goes to level 0. Illegal codes then hold both bridges and flag cmd_err.
        add(1, 0, 0, 8'd0, 4'b0100, 8'h91, 2'b01, 2'b00, 0);
        add(1, 0, 0, 8'd0, 4'b0100, 8'h95, 2'b00, 2'b00, 0);
        add(1, 0, 0, 8'd0, 4'b0110, 8'h95, 2'b00, 2'b01, 0);
        add(1, 0, 0, 8'd0, 4'b0110, 8'h95, 2'b00, 2'b01, 0);
        add(1, 0, 0, 8'd0, 4'b1010, 8'h95, 2'b00, 2'b11, 0);
        // A fault mid-DEAD trips everything. fault_in wins over fault_clr.
        add(1, 0, 0, 8'd3, 4'b0101, 8'h94, 2'b01, 2'b00, 0);
        add(1, 1, 0, 8'd3, 4'b0101, 8'h00, 2'b00, 2'b00, 1);
        add(1, 0, 0, 8'd3, 4'b0101, 8'h00, 2'b00, 2'b00, 1);
        add(1, 1, 1, 8'd3, 4'b0101, 8'h00, 2'b00, 2'b00, 1);
        add(1, 0, 1, 8'd3, 4'b0101, 8'h00, 2'b00, 2'b00, 0);
        for (int i = 0; i < 4; i++) add(1, 0, 0, 8'd3, 4'b0101, 8'h00, 2'b11, 2'b00, 0);
        add(1, 0, 0, 8'd3, 4'b0101, 8'h96, 2'b00, 2'b00, 0);
        // en=0 forces OFF. Re-enabling with an illegal code on bridge0 gives level 0.
        add(0, 0, 0, 8'd0, 4'b0101, 8'h00, 2'b00, 2'b00, 0);
        add(1, 0, 0, 8'd0, 4'b0110, 8'h00, 2'b11, 2'b01, 0);
        add(1, 0, 0, 8'd0, 4'b0110, 8'h95, 2'b00, 2'b01, 0);

        // Reset state.
        rst_n = 1'b0; en = 1'b0; fault_in = 1'b0; fault_clr = 1'b0;
        deadtime = 8'd0; cmd = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        check("reset", 8'h00, 2'b00, 2'b00, 1'b0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            en = vecs[i].en; fault_in = vecs[i].fi; fault_clr = vecs[i].fc;
            deadtime = vecs[i].dt; cmd = vecs[i].cmd;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), vecs[i].gate, vecs[i].busy, vecs[i].err, vecs[i].fault);
        end

        // Asynchronous reset mid-DEAD opens all gates without waiting for an edge.
        en = 1'b1; fault_in = 1'b0; fault_clr = 1'b0; deadtime = 8'd5; cmd = 4'b0111;
        @(posedge clk);
        #1;
        check("dead_before_rst", 8'h91, 2'b01, 2'b00, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst", 8'h00, 2'b00, 2'b00, 1'b0);
        @(posedge clk);
        #1;
        check("rst_held", 8'h00, 2'b00, 2'b00, 1'b0);
        rst_n = 1'b1; deadtime = 8'd0;
        @(posedge clk);
        #1;
        check("rst_exit_dead", 8'h00, 2'b11, 2'b00, 1'b0);
        @(posedge clk);
        #1;
        check("rst_exit_steady", 8'h99, 2'b00, 2'b00, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hbridge_deadtime.md
HBRIDGE_DEADTIME -- requirements
Module: hbridge_deadtime

Interface
REQ-001 SHALL have parameter N_BRIDGE, default 2: number of independent H-bridges.
REQ-002 SHALL have parameter DT_W, default 8: deadtime counter width.
REQ-003 SHALL have parameter INV_MASK[N_BRIDGE-1:0], default 2'b10: bridges whose +1/-1 gate patterns are swapped.
REQ-004 SHALL have port clk  in  1: single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  in  1: asynchronous active-low reset.
REQ-006 SHALL have port en  in  1: global enable; low forces all bridges OFF.
REQ-007 SHALL have port fault_in  in  1: synchronous emergency trip request.
REQ-008 SHALL have port fault_clr  in  1: single-cycle pulse that clears the latched fault.
REQ-009 SHALL have port deadtime  in  DT_W: deadtime length in cycles minus one.
REQ-010 SHALL have port cmd  in  2*N_BRIDGE: signed 2-bit level per bridge, bridge i at [2i+1:2i]; +1, 0 or -1.
REQ-011 SHALL have port gate  out  4*N_BRIDGE: switch pattern per bridge, bridge i at [4i+3:4i].
REQ-012 SHALL have port busy  out  N_BRIDGE: bridge i is in DEAD.
REQ-013 SHALL have port cmd_err  out  N_BRIDGE: bridge i currently sees the illegal code 2'b10.
REQ-014 SHALL have port fault  out  1: latched trip status.

Function
REQ-015 Level patterns (non-inverted) SHALL be +1=4'b0110, 0=4'b0101, -1=4'b1001 and OFF=4'b0000; INV_MASK[i] swaps the +1 and -1 patterns.
REQ-016 Each bridge SHALL run its own FSM with states OFF, STEADY and DEAD, holding registers cur (level), tgt (level) and cnt (DT_W bits).
REQ-017 gate SHALL be Moore: STEADY drives pat(cur), DEAD drives pat(cur) AND pat(tgt), OFF drives 4'b0000; there is no combinational path from inputs to gate.
REQ-018 STEADY SHALL go to DEAD when a legal cmd differs from cur: tgt=cmd, cnt=0, deadtime latched into dt_lat.
REQ-019 DEAD SHALL increment cnt each cycle and go to STEADY with cur=tgt when cnt==dt_lat, so DEAD lasts dt_lat+1 cycles (deadtime=0 gives 1 cycle).
REQ-020 In DEAD, a legal cmd that differs from both tgt and cur SHALL set tgt=cmd, reset cnt to 0 and re-latch deadtime.
REQ-021 In DEAD, a cmd equal to cur SHALL return the bridge to STEADY on the next edge, because no complementary switch was turned on.
REQ-022 The illegal cmd code 2'b10 SHALL be ignored (treated as hold) and SHALL assert cmd_err combinationally.
REQ-023 OFF SHALL go to DEAD when en=1 and fault=0: cur=OFF so the gate stays 4'b0000, tgt=cmd (illegal code maps to 0), cnt=0.
REQ-024 en=0, or fault_in=1, or fault=1 SHALL force every bridge to OFF on the next edge from any state, with priority over all transitions.
REQ-025 fault SHALL set on fault_in=1 and clear only on fault_clr=1 with fault_in=0; if both are high in the same cycle, fault_in wins.
REQ-026 cnt SHALL never wrap, because the comparison with dt_lat terminates DEAD first.
REQ-027 Bridges SHALL be fully independent except for the shared en, fault and deadtime.

Reset
REQ-028 rst_n=0 SHALL immediately drive all FSMs to OFF, gate=0, busy=0, fault=0, cnt=0, dt_lat=0, cur=tgt=0.
REQ-029 Deassertion of rst_n SHALL take effect on the first clk edge, with REQ-023 governing exit from OFF.
REQ-030 Reset mid-DEAD SHALL abandon the transition with no gate glitch above 4'b0000.

Structure
REQ-031 Package hbridge_pkg SHALL hold the level encodings, the four gate patterns, the FSM state typedef and the illegal-code constant.
REQ-032 Sub-module hbridge_dt_chan SHALL implement one bridge (FSM, counter, pattern logic, INV bit parameter) and be instantiated N_BRIDGE times by generate.

Verification
REQ-033 Reset, en=1, cmd0=0, deadtime=3 -> gate0 stays 0000 for 4 cycles, then 0101; busy0 high for exactly 4 cycles.
REQ-034 Bridge0 STEADY +1, cmd0 -> -1, deadtime=2 -> gate0 0000 for 3 cycles, then 1001; bridge1 (inverted) at +1 shows 1001.
REQ-035 Bridge0 in DEAD +1->0 (gate 0100) at cnt=1, cmd0 -> -1 -> gate0 0000, cnt restarts, 1001 after dt_lat+1 cycles.
REQ-036 fault_in pulse mid-DEAD -> all gates 0000 next edge, fault=1 held; fault_clr -> bridges re-enter through DEAD at 0000 and reach their cmd levels.
REQ-037 cmd0=2'b10 in STEADY 0 -> cmd_err0=1, gate0 stays 0101, no DEAD entry; deadtime=0 transitions -> exactly 1 DEAD cycle.
